// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the RISC-V M-extension multiply/divide unit:
// instruction fields, operation codes, FSM states and divide special cases.
package muldiv_unit_pkg;

    localparam logic [6:0] OPCODE_OP = 7'b0110011;
    localparam logic [6:0] FUNCT7_M  = 7'b0000001;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SP_NONE = 2'd0,
        SP_DIV0 = 2'd1,
        SP_OVF  = 2'd2
    } spec_e;

    function automatic logic is_m_ext(input logic [31:0] inst);
        return (inst[6:0] == OPCODE_OP) && (inst[31:25] == FUNCT7_M);
    endfunction

    function automatic logic is_div(input op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_quot(input op_e op);
        return op inside {OP_DIV, OP_DIVU};
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Issue/result bus of the multiply/divide unit; the pipeline is the master.
interface muldiv_unit_if #(
    parameter int XLEN = 32
) ();
    logic            flush;
    logic            valid_in;
    logic [31:0]     inst;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            in_ready;
    logic            is_muldiv;
    logic            busy;
    logic            result_valid;
    logic            result_ready;
    logic [XLEN-1:0] result;

    modport master (
        output flush, valid_in, inst, rs1_val, rs2_val, result_ready,
        input  in_ready, is_muldiv, busy, result_valid, result
    );

    modport slave (
        input  flush, valid_in, inst, rs1_val, rs2_val, result_ready,
        output in_ready, is_muldiv, busy, result_valid, result
    );
endinterface

// File: rtl/muldiv_divider.sv
// Radix-2 restoring divider on unsigned magnitudes, one quotient bit per cycle,
// MSB first. quotient/remainder are the final values while done is high.
module muldiv_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            done
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    logic [XLEN-1:0] rem_q, quo_q, dvs_q;
    logic [CW-1:0]   cnt;
    logic            run;
    logic [XLEN:0]   shifted, diff;
    logic            ge;
    logic [XLEN-1:0] rem_n, quo_n;

    // quo_q shifts dividend bits out of its top while quotient bits enter at the bottom.
    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign diff    = shifted - {1'b0, dvs_q};
    assign ge      = ~diff[XLEN];
    assign rem_n   = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    assign quo_n   = {quo_q[XLEN-2:0], ge};

    assign quotient  = quo_n;
    assign remainder = rem_n;
    assign done      = run && (cnt == LAST);

    // NOTE: registers take <= so every flop samples pre-edge values; = here would chain them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt   <= '0;
            run   <= 1'b0;
        end else if (abort) begin
            cnt <= '0;
            run <= 1'b0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
            cnt   <= '0;
            run   <= 1'b1;
        end else if (run) begin
            rem_q <= rem_n;
            quo_q <= quo_n;
            cnt   <= cnt + CW'(1);
            if (cnt == LAST) run <= 1'b0;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// M-extension multiply/divide unit: decode, sign handling, special cases,
// single-cycle or shift-add multiplier, and the IDLE/MUL/DIV/DONE sequencer.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit FAST_MUL = 1'b1
) (
    input logic          clk,
    input logic          rst,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state;
    logic [CW-1:0]     cnt;
    op_e               op_q;
    spec_e             spec_q;
    logic              neg_q, neg_r;
    logic [XLEN-1:0]   a_raw, a_mag, b_mag;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   result_q;
    logic              result_valid_q;

    op_e               op_in;
    spec_e             spec_in;
    logic              accept, sa, sb, a_neg, b_neg;
    logic [XLEN-1:0]   a_in_mag, b_in_mag;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_step, mul_fast;
    logic [XLEN-1:0]   done_res;
    logic              div_start, div_done;
    logic [XLEN-1:0]   div_q, div_r;

    assign bus.is_muldiv    = is_m_ext(bus.inst);
    assign bus.in_ready     = (state == ST_IDLE);
    assign bus.busy         = (state != ST_IDLE);
    assign bus.result_valid = result_valid_q;
    assign bus.result       = result_q;

    assign op_in  = op_e'(bus.inst[14:12]);
    assign accept = bus.valid_in && bus.is_muldiv && bus.in_ready && !bus.flush;

    // NOTE: every always_comb output gets a value before any branch, so no latch is inferred.
    always_comb begin
        sa       = op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        sb       = op_in inside {OP_MULH, OP_DIV, OP_REM};
        a_neg    = sa && bus.rs1_val[XLEN-1];
        b_neg    = sb && bus.rs2_val[XLEN-1];
        a_in_mag = a_neg ? -bus.rs1_val : bus.rs1_val;
        b_in_mag = b_neg ? -bus.rs2_val : bus.rs2_val;
        spec_in  = SP_NONE;
        if (is_div(op_in)) begin
            if (bus.rs2_val == '0)
                spec_in = SP_DIV0;
            else if (sb && bus.rs1_val == MOST_NEG && bus.rs2_val == '1)
                spec_in = SP_OVF;
        end
    end

    function automatic logic [XLEN-1:0] mul_out(input op_e op, input logic neg,
                                                input logic [2*XLEN-1:0] p);
        logic [2*XLEN-1:0] s;
        s = neg ? -p : p;
        return (op == OP_MUL) ? s[XLEN-1:0] : s[2*XLEN-1:XLEN];
    endfunction

    function automatic logic [XLEN-1:0] div_out(input op_e op, input logic nq, input logic nr,
                                                input logic [XLEN-1:0] q, input logic [XLEN-1:0] r);
        if (is_quot(op)) return nq ? -q : q;
        return nr ? -r : r;
    endfunction

    // Shift-add step: add the multiplicand into the upper half when the low bit is set.
    assign mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, a_mag} : '0);
    assign mul_step = {mul_sum, prod[XLEN-1:1]};
    assign mul_fast = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};

    always_comb begin
        done_res = mul_out(op_q, neg_q, mul_fast);
        if (spec_q == SP_DIV0)
            done_res = is_quot(op_q) ? '1 : a_raw;
        else if (spec_q == SP_OVF)
            done_res = is_quot(op_q) ? a_raw : '0;
    end

    assign div_start = accept && is_div(op_in) && (spec_in == SP_NONE);

    muldiv_divider #(.XLEN(XLEN)) u_divider (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .abort     (bus.flush),
        .dividend  (a_in_mag),
        .divisor   (b_in_mag),
        .quotient  (div_q),
        .remainder (div_r),
        .done      (div_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            op_q           <= OP_MUL;
            spec_q         <= SP_NONE;
            neg_q          <= 1'b0;
            neg_r          <= 1'b0;
            a_raw          <= '0;
            a_mag          <= '0;
            b_mag          <= '0;
            prod           <= '0;
        end else if (bus.flush) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            result_valid_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q   <= op_in;
                        spec_q <= spec_in;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        a_raw  <= bus.rs1_val;
                        a_mag  <= a_in_mag;
                        b_mag  <= b_in_mag;
                        prod   <= {{XLEN{1'b0}}, b_in_mag};
                        cnt    <= '0;
                        if (spec_in != SP_NONE || (!is_div(op_in) && FAST_MUL))
                            state <= ST_DONE;
                        else if (!is_div(op_in))
                            state <= ST_MUL;
                        else
                            state <= ST_DIV;
                    end
                end
                ST_MUL: begin
                    prod <= mul_step;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state          <= ST_DONE;
                        result_q       <= mul_out(op_q, neg_q, mul_step);
                        result_valid_q <= 1'b1;
                    end
                end
                ST_DIV: begin
                    if (div_done) begin
                        state          <= ST_DONE;
                        result_q       <= div_out(op_q, neg_q, neg_r, div_q, div_r);
                        result_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // Fast multiplies and special cases form their result in the first DONE cycle.
                    if (!result_valid_q) begin
                        result_q       <= done_res;
                        result_valid_q <= 1'b1;
                    end else if (bus.result_ready) begin
                        state          <= ST_IDLE;
                        result_valid_q <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter XLEN SHALL default to 32 and set the operand and result width; it SHALL be legal for 32 and 64.
REQ-003 Parameter FAST_MUL SHALL default to 1; 1 selects a single-cycle multiply and 0 selects an iterative shift-add multiply.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 flush  in  1  synchronous abort of any in-flight operation.
REQ-007 valid_in  in  1  inst and operands are valid.
REQ-008 inst  in  32  full instruction word.
REQ-009 rs1_val  in  XLEN  operand 1.
REQ-010 rs2_val  in  XLEN  operand 2.
REQ-011 in_ready  out  1  the block can accept an operation.
REQ-012 is_muldiv  out  1  combinational decode: inst is an RV M-extension op.
REQ-013 busy  out  1  the block is in MUL, DIV or DONE; used as the pipeline stall.
REQ-014 result_valid  out  1  result holds a completed value.
REQ-015 result_ready  in  1  the consumer takes the result.
REQ-016 result  out  XLEN  operation result.

Function
REQ-017 is_muldiv SHALL be 1 when opcode = 0110011 and funct7 = 0000001; otherwise it SHALL be 0.
REQ-018 funct3 SHALL select the operation:
- 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
- 100 DIV, 101 DIVU, 110 REM, 111 REMU
REQ-019 An operation SHALL be accepted on a rising edge where valid_in & is_muldiv & in_ready & !flush; valid_in with is_muldiv=0 SHALL be ignored.
REQ-020 The FSM states SHALL be IDLE, MUL, DIV, DONE, and in_ready SHALL equal (state == IDLE).
REQ-021 IDLE SHALL transition on accept as follows:
- to DONE for FAST_MUL multiplies and for divide special cases;
- to MUL for iterative multiplies;
- to DIV otherwise.
REQ-022 MUL and DIV SHALL each run exactly XLEN iterations, counted by a clog2(XLEN)-bit counter starting at 0, then go to DONE.
REQ-023 Latency from the accept edge N SHALL be: result_valid first high after edge N+1 for the fast path and special cases, and after edge N+XLEN for iterative operations.
REQ-024 Signed operands SHALL be converted to magnitudes before the core operation:
- MULH, DIV, REM: both operands signed;
- MULHSU: rs1 signed, rs2 unsigned.
REQ-025 The final result SHALL be negated when the operand signs differ; a remainder SHALL take the sign of the dividend.
REQ-026 Multiply results SHALL be taken from the 2*XLEN-bit product: low half for MUL, high half otherwise.
REQ-027 Division SHALL use radix-2 restoring, one quotient bit per cycle, MSB first.
REQ-028 Divide by zero SHALL produce a quotient of all ones and a remainder equal to rs1.
REQ-029 Signed overflow (rs1 = -2^(XLEN-1), rs2 = -1) SHALL produce quotient = rs1 and remainder = 0.
REQ-030 DONE SHALL hold result stable with result_valid=1 until result_ready=1, then go to IDLE on that edge.
REQ-031 flush SHALL force IDLE on the next edge from any state and clear result_valid; flush SHALL take priority over accept and result_ready.
REQ-032 Operands and the decoded op SHALL be captured at accept, so later changes of inputs SHALL NOT affect the result.
REQ-033 result SHALL retain its last value outside DONE; the consumer SHALL qualify it with result_valid.

Reset
REQ-034 On rst=1 the block SHALL immediately set state=IDLE, counter=0, result=0, result_valid=0 and busy=0, with in_ready=1 whenever reset is deasserted.
REQ-035 Reset asserted mid-operation SHALL abandon the operation, with no result ever presented.

Structure
REQ-036 The shared constants header SHALL hold:
- the R-format opcode and the M funct7 (0000001);
- the eight M funct3 codes;
- the FSM state encoding.
REQ-037 The iterative restoring divider SHALL be a sub-module muldiv_divider with start, XLEN-bit magnitudes, quotient, remainder and a done strobe.
REQ-038 The FSM, sign handling, special-case detection and multiplier SHALL reside in muldiv_unit.

Verification (XLEN=32)
REQ-039 MUL 7 x 0xFFFFFFFD SHALL give 0xFFFFFFEB, with result_valid after edge N+1 when FAST_MUL=1 and after edge N+32 when FAST_MUL=0.
REQ-040 MULH 0x80000000 x 0x80000000 SHALL give 0x40000000, MULHU 0xFFFFFFFF x 0xFFFFFFFF SHALL give 0xFFFFFFFE, and MULHSU 0xFFFFFFFF x 2 SHALL give 0xFFFFFFFF.
REQ-041 DIV 0xFFFFFFF9 / 2 SHALL give 0xFFFFFFFD and REM SHALL give 0xFFFFFFFF, with result_valid exactly 32 edges after accept and busy high throughout.
REQ-042 Special cases SHALL give these results, each with result_valid after 1 edge:
- DIVU 5/0 gives 0xFFFFFFFF;
- REM 5/0 gives 5;
- DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000;
- REM of the same operands gives 0.
REQ-043 flush asserted on the 10th DIV cycle SHALL return the block to IDLE next edge with result_valid never high; a simultaneous new valid_in SHALL NOT be accepted.
REQ-044 result_ready held low 3 cycles SHALL keep result and result_valid stable with in_ready=0, and rst pulsed mid-DIV SHALL clear all outputs asynchronously.
